// File: rtl/esc_cmd_sequencer.sv
// Frame-aligned speed/offset command sequencer for ESC_interface: arming phase,
// per-frame slew limiting of SPEED, controlled stop and latched emergency stop.
module esc_cmd_sequencer #(
  parameter int unsigned FRAME_CYCLES = 1048576,
  parameter int unsigned ARM_FRAMES   = 50,
  parameter int unsigned MAX_STEP     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        cmd_vld,
  input  logic [10:0] cmd_spd,
  input  logic [9:0]  cmd_off,
  input  logic        estop,
  output logic [10:0] SPEED,
  output logic [9:0]  OFF,
  output logic        frm_tick,
  output logic        armed,
  output logic        fault
);

  localparam int unsigned FCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned ACW = $clog2(ARM_FRAMES + 1);

  localparam logic [FCW-1:0] FRM_LAST = FCW'(FRAME_CYCLES - 1);
  localparam logic [ACW-1:0] ARM_LAST = ACW'(ARM_FRAMES - 1);
  localparam logic [10:0]    STEP     = 11'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    RUN,
    STOP
  } state_t;

  state_t         state_q, state_d;
  logic [FCW-1:0] frm_cnt_q, frm_cnt_d;
  logic [ACW-1:0] arm_cnt_q, arm_cnt_d;
  logic [10:0]    spd_q, spd_d;
  logic [9:0]     off_q, off_d;
  logic [10:0]    tgt_spd_q, tgt_spd_d;
  logic [9:0]     tgt_off_q, tgt_off_d;
  logic           fault_q, fault_d;

  logic           tick;
  logic [10:0]    up_diff;
  logic [10:0]    dn_diff;
  logic [10:0]    up_step;
  logic [10:0]    dn_step;
  logic [10:0]    stop_step;

  assign tick = (frm_cnt_q == FRM_LAST);

  // Differences are only used under the matching magnitude compare, so they never wrap.
  always_comb begin
    up_diff   = tgt_spd_q - spd_q;
    dn_diff   = spd_q - tgt_spd_q;
    up_step   = (up_diff > STEP) ? STEP : up_diff;
    dn_step   = (dn_diff > STEP) ? STEP : dn_diff;
    stop_step = (spd_q > STEP) ? STEP : spd_q;
  end

  always_comb begin
    state_d   = state_q;
    frm_cnt_d = tick ? '0 : frm_cnt_q + 1'b1;
    arm_cnt_d = arm_cnt_q;
    spd_d     = spd_q;
    off_d     = off_q;
    tgt_spd_d = tgt_spd_q;
    tgt_off_d = tgt_off_q;
    fault_d   = fault_q;

    if (cmd_vld && !fault_q) begin
      tgt_spd_d = cmd_spd;
      tgt_off_d = cmd_off;
    end

    case (state_q)
      IDLE: begin
        spd_d = '0;
        if (arm) begin
          if (!fault_q) begin
            state_d   = ARMING;
            arm_cnt_d = '0;
          end
        end else begin
          fault_d = 1'b0;
        end
      end
      ARMING: begin
        spd_d = '0;
        if (!arm) begin
          state_d   = IDLE;
          arm_cnt_d = '0;
        end else if (tick) begin
          off_d = tgt_off_q;
          if (arm_cnt_q == ARM_LAST) begin
            state_d   = RUN;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        // Dropping arm takes precedence over a coincident tick: no ramp, no OFF update.
        if (!arm) begin
          state_d = STOP;
        end else if (tick) begin
          off_d = tgt_off_q;
          if (tgt_spd_q > spd_q) begin
            spd_d = spd_q + up_step;
          end else if (tgt_spd_q < spd_q) begin
            spd_d = spd_q - dn_step;
          end
        end
      end
      STOP: begin
        if (spd_q == '0) begin
          state_d = IDLE;
        end else if (tick) begin
          spd_d = spd_q - stop_step;
        end
      end
      default: begin
        state_d = IDLE;
        spd_d   = '0;
      end
    endcase

    if (estop) begin
      state_d   = IDLE;
      arm_cnt_d = '0;
      spd_d     = '0;
      tgt_spd_d = '0;
      tgt_off_d = tgt_off_q;
      fault_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frm_cnt_q <= '0;
      arm_cnt_q <= '0;
      spd_q     <= '0;
      off_q     <= '0;
      tgt_spd_q <= '0;
      tgt_off_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frm_cnt_q <= frm_cnt_d;
      arm_cnt_q <= arm_cnt_d;
      spd_q     <= spd_d;
      off_q     <= off_d;
      tgt_spd_q <= tgt_spd_d;
      tgt_off_q <= tgt_off_d;
      fault_q   <= fault_d;
    end
  end

  assign SPEED    = spd_q;
  assign OFF      = off_q;
  assign frm_tick = tick;
  assign armed    = (state_q == RUN);
  assign fault    = fault_q;

endmodule

// File: tb/tb_esc_cmd_sequencer.sv
// Directed bench for esc_cmd_sequencer with short frames (16 cycles, 3 arming frames).
module tb_esc_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        cmd_vld;
  logic [10:0] cmd_spd;
  logic [9:0]  cmd_off;
  logic        estop;
  logic [10:0] SPEED;
  logic [9:0]  OFF;
  logic        frm_tick;
  logic        armed;
  logic        fault;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;
  int          last_tick = -1;

  esc_cmd_sequencer #(
    .FRAME_CYCLES(16),
    .ARM_FRAMES  (3),
    .MAX_STEP    (64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arm     (arm),
    .cmd_vld (cmd_vld),
    .cmd_spd (cmd_spd),
    .cmd_off (cmd_off),
    .estop   (estop),
    .SPEED   (SPEED),
    .OFF     (OFF),
    .frm_tick(frm_tick),
    .armed   (armed),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Tick spacing must stay exactly one frame whenever reset is not in play.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_tick = -1;
    end else if (frm_tick) begin
      if (last_tick >= 0) check("tick_period", cyc - last_tick, 16);
      last_tick = cyc;
    end
  end

  task automatic wait_tick_hi();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frm_tick && n < 40);
    if (!frm_tick) check("tick_timeout", 0, 1);
  endtask

  task automatic next_tick();
    wait_tick_hi();
    @(negedge clk);
  endtask

  task automatic pulse_cmd(input int spd, input int off);
    cmd_vld = 1'b1;
    cmd_spd = 11'(spd);
    cmd_off = 10'(off);
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    arm     = 1'b0;
    cmd_vld = 1'b0;
    cmd_spd = '0;
    cmd_off = '0;
    estop   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_speed", int'(SPEED), 0);
    check("rst_off", int'(OFF), 0);
    check("rst_tick", int'(frm_tick), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_fault", int'(fault), 0);

    // Arming then ramp to 200
    rst_n = 1'b1;
    arm   = 1'b1;
    pulse_cmd(200, 'h155);
    for (int i = 1; i <= 3; i++) begin
      next_tick();
      check($sformatf("arm_speed%0d", i), int'(SPEED), 0);
      check($sformatf("arm_armed%0d", i), int'(armed), (i == 3) ? 1 : 0);
    end
    check("arm_off", int'(OFF), 'h155);
    next_tick(); check("ramp_up64", int'(SPEED), 64);
    next_tick(); check("ramp_up128", int'(SPEED), 128);
    next_tick(); check("ramp_up192", int'(SPEED), 192);
    next_tick(); check("ramp_up200", int'(SPEED), 200);

    // Ramp down to 10, then a command coincident with a tick
    pulse_cmd(10, 'h155);
    next_tick(); check("ramp_dn136", int'(SPEED), 136);
    next_tick(); check("ramp_dn72", int'(SPEED), 72);
    next_tick(); check("ramp_dn10", int'(SPEED), 10);
    wait_tick_hi();
    pulse_cmd(200, 'h155);
    check("cmd_on_tick_old", int'(SPEED), 10);
    next_tick(); check("cmd_on_tick74", int'(SPEED), 74);
    next_tick(); check("cmd_on_tick138", int'(SPEED), 138);
    next_tick(); check("cmd_on_tick200", int'(SPEED), 200);

    // Stop with arm re-asserted during STOP
    arm = 1'b0;
    @(negedge clk);
    arm = 1'b1;
    check("stop_armed", int'(armed), 0);
    next_tick(); check("stop136", int'(SPEED), 136);
    next_tick(); check("stop72", int'(SPEED), 72);
    next_tick(); check("stop8", int'(SPEED), 8);
    next_tick(); check("stop0", int'(SPEED), 0);
    for (int i = 1; i <= 3; i++) begin
      next_tick();
      check($sformatf("rearm_speed%0d", i), int'(SPEED), 0);
      check($sformatf("rearm_armed%0d", i), int'(armed), (i == 3) ? 1 : 0);
    end
    next_tick(); check("rearm_up64", int'(SPEED), 64);
    next_tick(); check("rearm_up128", int'(SPEED), 128);

    // Emergency stop at 128 with a coincident command
    estop   = 1'b1;
    cmd_vld = 1'b1;
    cmd_spd = 11'd300;
    cmd_off = 10'h2AA;
    @(negedge clk);
    estop   = 1'b0;
    cmd_vld = 1'b0;
    check("estop_speed", int'(SPEED), 0);
    check("estop_fault", int'(fault), 1);
    check("estop_armed", int'(armed), 0);
    check("estop_off_hold", int'(OFF), 'h155);
    pulse_cmd(500, 'h0AA);
    next_tick(); check("fault_hold_speed", int'(SPEED), 0);
    next_tick(); check("fault_hold_armed", int'(armed), 0);
    check("fault_hold_fault", int'(fault), 1);
    check("fault_hold_off", int'(OFF), 'h155);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    check("fault_clear", int'(fault), 0);
    arm = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      next_tick();
      check($sformatf("post_fault_armed%0d", i), int'(armed), (i == 3) ? 1 : 0);
    end
    next_tick(); check("post_fault_tgt0", int'(SPEED), 0);

    // Aborted arming, full re-arm, then full-scale ramp
    arm = 1'b0;
    repeat (3) @(negedge clk);
    arm = 1'b1;
    pulse_cmd(2047, 'h3FF);
    next_tick();
    check("abort_off", int'(OFF), 'h3FF);
    next_tick();
    check("abort_armed", int'(armed), 0);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    arm = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      next_tick();
      check($sformatf("full_arm_armed%0d", i), int'(armed), (i == 3) ? 1 : 0);
      check($sformatf("full_arm_speed%0d", i), int'(SPEED), 0);
    end
    for (int k = 1; k <= 32; k++) begin
      next_tick();
      check($sformatf("max_ramp%0d", k), int'(SPEED), (k < 32) ? 64 * k : 2047);
    end
    next_tick(); check("max_hold", int'(SPEED), 2047);

    // Asynchronous reset mid-ramp
    pulse_cmd(0, 'h3FF);
    next_tick(); check("pre_rst_ramp", int'(SPEED), 1983);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_speed", int'(SPEED), 0);
    check("async_rst_off", int'(OFF), 0);
    check("async_rst_armed", int'(armed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frm_tick && n < 40);
    check("rst_first_tick", n, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
